// File: rtl/predict_btb_if.sv
// predict_btb_if: lookup, update and status signals of the branch target buffer.
// master = fetch/execute side, slave = the BTB itself.
interface predict_btb_if #(
  parameter int unsigned PC_W = 13
);
  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] pc2;
  logic            hit_predict1;
  logic            hit_predict2;
  logic [PC_W-1:0] pre_pc1;
  logic [PC_W-1:0] pre_pc2;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            busy;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispred;

  modport master (
    output pc1, pc2, upd_valid, upd_pc, upd_taken, upd_target,
    input  hit_predict1, hit_predict2, pre_pc1, pre_pc2, busy, stat_hits, stat_mispred
  );

  modport slave (
    input  pc1, pc2, upd_valid, upd_pc, upd_taken, upd_target,
    output hit_predict1, hit_predict2, pre_pc1, pre_pc2, busy, stat_hits, stat_mispred
  );
endinterface

// File: rtl/predict_btb.sv
// predict_btb: dual-lookup branch target buffer with in-entry saturating counters.
// Lookups are registered on the falling clock edge; updates run a two-stage
// read-modify-write on the rising edge with U2->U1 forwarding.
// A sweep FSM clears every entry after reset.
// Optional statistics counters are built when PREDICT_STATS_EN is defined.
module predict_btb #(
  parameter int unsigned PC_W  = 13,
  parameter int unsigned IDX_W = 11,
  parameter int unsigned CNT_W = 2
) (
  input logic          CLK,
  input logic          RST,
  predict_btb_if.slave bus
);

  localparam int unsigned TAG_W = PC_W - IDX_W;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CntWeak = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } entry_t;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  entry_t mem [DEPTH];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             busy;

  // U1 stage registers
  logic             u1_valid_q;
  logic [PC_W-1:0]  u1_pc_q;
  logic             u1_taken_q;
  logic [PC_W-1:0]  u1_target_q;
  entry_t           u1_ent_q, u1_ent_d;

  // U2 combinational results
  logic [IDX_W-1:0] u1_idx;
  logic [TAG_W-1:0] u1_tag;
  logic             u2_hit;
  logic             u2_we;
  entry_t           u2_new;
  logic [IDX_W-1:0] upd_idx;

  // Lookup path
  entry_t           rd1, rd2;
  logic             lk_hit1, lk_hit2;
  logic             hit1_q, hit2_q;
  logic [PC_W-1:0]  pre1_q, pre2_q;

  assign busy     = (state_q == StClear);
  assign bus.busy = busy;

  // Sweep FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StClear;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep FSM next state: walk every index once, then run
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == StClear) begin
      sweep_d = sweep_q + IDX_W'(1);
      if (&sweep_q) begin
        state_d = StRun;
      end
    end
  end

  // U2: compute the replacement entry from the captured update
  always_comb begin
    u1_idx = u1_pc_q[IDX_W-1:0];
    u1_tag = u1_pc_q[PC_W-1:IDX_W];
    u2_hit = u1_ent_q.valid && (u1_ent_q.tag == u1_tag);
    u2_new = u1_ent_q;
    u2_we  = 1'b0;
    if (u1_valid_q) begin
      if (u2_hit) begin
        u2_we = 1'b1;
        if (u1_taken_q) begin
          if (u1_ent_q.cnt != CntMax) begin
            u2_new.cnt = u1_ent_q.cnt + CNT_W'(1);
          end
          u2_new.target = u1_target_q;
        end else if (u1_ent_q.cnt != '0) begin
          u2_new.cnt = u1_ent_q.cnt - CNT_W'(1);
        end
      end else if (u1_taken_q) begin
        u2_we         = 1'b1;
        u2_new.valid  = 1'b1;
        u2_new.cnt    = CntWeak;
        u2_new.tag    = u1_tag;
        u2_new.target = u1_target_q;
      end
    end
  end

  // U1 read with forwarding: the array is not yet written when U2 targets the same index
  always_comb begin
    upd_idx  = bus.upd_pc[IDX_W-1:0];
    u1_ent_d = mem[upd_idx];
    if (u2_we && (u1_idx == upd_idx)) begin
      u1_ent_d = u2_new;
    end
  end

  // U1 capture; updates arriving during the sweep are dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      u1_valid_q <= 1'b0;
    end else begin
      u1_valid_q <= bus.upd_valid && !busy;
      if (bus.upd_valid && !busy) begin
        u1_pc_q     <= bus.upd_pc;
        u1_taken_q  <= bus.upd_taken;
        u1_target_q <= bus.upd_target;
        u1_ent_q    <= u1_ent_d;
      end
    end
  end

  // Single array write port shared by the sweep and U2
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy) begin
        mem[sweep_q] <= '0;
      end else if (u2_we) begin
        mem[u1_idx] <= u2_new;
      end
    end
  end

  // Lookup decode for both ports
  always_comb begin
    rd1     = mem[bus.pc1[IDX_W-1:0]];
    rd2     = mem[bus.pc2[IDX_W-1:0]];
    lk_hit1 = rd1.valid && (rd1.tag == bus.pc1[PC_W-1:IDX_W]) && rd1.cnt[CNT_W-1];
    lk_hit2 = rd2.valid && (rd2.tag == bus.pc2[PC_W-1:IDX_W]) && rd2.cnt[CNT_W-1];
  end

  // Lookup outputs registered on the falling edge so they see same-cycle writes
  always_ff @(negedge CLK) begin
    if (busy) begin
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      pre1_q <= '0;
      pre2_q <= '0;
    end else begin
      hit1_q <= lk_hit1;
      hit2_q <= lk_hit2;
      pre1_q <= rd1.target;
      pre2_q <= rd2.target;
    end
  end

  assign bus.hit_predict1 = hit1_q;
  assign bus.hit_predict2 = hit2_q;
  assign bus.pre_pc1      = pre1_q;
  assign bus.pre_pc2      = pre2_q;

`ifdef PREDICT_STATS_EN
  logic [31:0] stat_hits_q, stat_mispred_q;
  logic        u2_old_pred;

  assign u2_old_pred = u2_hit && u1_ent_q.cnt[CNT_W-1];

  // Each registered port-1 hit lives exactly one cycle, so it is counted once at the next rise
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else if (!busy) begin
      if (hit1_q) begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
      if (u1_valid_q && (u2_old_pred != u1_taken_q)) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign bus.stat_hits    = stat_hits_q;
  assign bus.stat_mispred = stat_mispred_q;
`else
  assign bus.stat_hits    = '0;
  assign bus.stat_mispred = '0;
`endif

endmodule
